// File: rtl/mult_pkg.sv
// Shared constants for the signed shift-add multiplier slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: DEFAULT_WIDTH, the operand width used when a module is not overridden.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/mult_datapath_add_sub.sv
// N-bit ripple adder/subtractor built from full_adder cells.
// Latency: combinational.
// Backpressure: none; there is no handshake.
//
// Ports of add_sub_n:
//   a, b  in   N  operands
//   sub   in   1  0: sum = a + b, 1: sum = a - b
//   sum   out  N  result modulo 2^N
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module add_sub_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);
  logic [N-1:0] b_eff;
  logic [N-1:0] carry;

  // Subtraction is a + ~b + 1: invert b and feed sub in as the carry-in.
  assign b_eff    = b ^ {N{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < N - 1; i++) begin : g_cell
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_eff[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // The carry out of the MSB is never used, so the top bit is only a sum bit.
  assign sum[N-1] = a[N-1] ^ b_eff[N-1] ^ carry[N-1];

endmodule

// File: rtl/mult_datapath.sv
// Register/arithmetic datapath (X, A, B) of the 8-bit signed shift-add multiplier.
// Latency: every strobe takes effect on the next Clk edge; M follows B combinationally.
// Backpressure: none; the control FSM sequences strobes and is never stalled.
//
// Ports:
//   Clk, Reset                 clock, async active-high reset
//   Switches[WIDTH-1:0]        multiplicand S, also the load value for B
//   Load_B, Clear_XA           load B / clear X and A
//   Addition, Subtraction      {X,A} <= sext(A) +/- sext(S)
//   Shift_En                   arithmetic shift right of {X,A,B}
//   Aval, Bval, X              register contents
//   M                          B[0], fed back to the FSM
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Switches,
  input  logic             Load_B,
  input  logic             Clear_XA,
  input  logic             Addition,
  input  logic             Subtraction,
  input  logic             Shift_En,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             M
);

  localparam int N = WIDTH + 1;

  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic             arith;
  logic [N-1:0]     sum;

  assign arith = Addition | Subtraction;

  // Subtraction wins over Addition simply by driving the sub input.
  add_sub_n #(.N(N)) u_add_sub (
    .a   ({a_q[WIDTH-1], a_q}),
    .b   ({Switches[WIDTH-1], Switches}),
    .sub (Subtraction),
    .sum (sum)
  );

  always_comb begin
    x_d = x_q;
    a_d = a_q;
    b_d = b_q;

    if (Clear_XA) begin
      x_d = 1'b0;
      a_d = '0;
    end else if (arith) begin
      x_d = sum[N-1];
      a_d = sum[WIDTH-1:0];
    end else if (Shift_En) begin
      // X is the sign, so it both holds and feeds A's MSB.
      a_d = {x_q, a_q[WIDTH-1:1]};
    end

    // Any add/sub in the same cycle suppresses the whole shift, B included;
    // a clear does not, so B takes the pre-clear A[0].
    if (Load_B) begin
      b_d = Switches;
    end else if (Shift_En && !arith) begin
      b_d = {a_q[0], b_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      x_q <= x_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign M    = b_q[0];

endmodule

// File: tb/tb_mult_datapath.sv
module tb_mult_datapath;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] Switches;
  logic       Load_B, Clear_XA, Addition, Subtraction, Shift_En;
  logic [7:0] Aval, Bval;
  logic       X, M;

  int vectors = 0;
  int miscompares = 0;

  mult_datapath dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Switches    (Switches),
    .Load_B      (Load_B),
    .Clear_XA    (Clear_XA),
    .Addition    (Addition),
    .Subtraction (Subtraction),
    .Shift_En    (Shift_En),
    .Aval        (Aval),
    .Bval        (Bval),
    .X           (X),
    .M           (M)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of strobes; inputs change 1 time unit after the edge and
  // outputs are sampled at that same point, away from the active edge.
  task automatic cyc(input logic [7:0] sw, input logic ld, input logic clr,
                     input logic add, input logic sub, input logic sh);
    Switches    = sw;
    Load_B      = ld;
    Clear_XA    = clr;
    Addition    = add;
    Subtraction = sub;
    Shift_En    = sh;
    @(posedge Clk);
    #1;
    Load_B      = 1'b0;
    Clear_XA    = 1'b0;
    Addition    = 1'b0;
    Subtraction = 1'b0;
    Shift_En    = 1'b0;
  endtask

  // Reference sequencing of the control FSM: load/clear, 7 x (add-if-M, shift),
  // then sub-if-M and a final shift.
  task automatic run_mult(input logic [7:0] s, input logic [7:0] b, output logic [15:0] p);
    cyc(b, 1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (M) cyc(s, 0, 0, 1, 0, 0);
      cyc(s, 0, 0, 0, 0, 1);
    end
    if (M) cyc(s, 0, 0, 0, 1, 0);
    cyc(s, 0, 0, 0, 0, 1);
    p = {Aval, Bval};
  endtask

  initial begin
    logic [15:0] prod;
    logic [7:0]  rs, rb;
    logic [15:0] exp_p;

    Reset = 1'b1;
    Switches = 8'h00;
    Load_B = 0; Clear_XA = 0; Addition = 0; Subtraction = 0; Shift_En = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_A", {8'h00, Aval}, 16'h0000);
    chk("rst_B", {8'h00, Bval}, 16'h0000);
    chk("rst_X", {15'h0, X}, 16'h0000);
    chk("rst_M", {15'h0, M}, 16'h0000);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Load-and-clear in one cycle.
    cyc(8'h07, 1, 1, 0, 0, 0);
    chk("ldclr_B", {8'h00, Bval}, 16'h0007);
    chk("ldclr_A", {8'h00, Aval}, 16'h0000);
    chk("ldclr_X", {15'h0, X}, 16'h0000);
    chk("ldclr_M", {15'h0, M}, 16'h0001);

    // Add a negative operand, then shift.
    cyc(8'hFB, 0, 0, 1, 0, 0);
    chk("add_A", {8'h00, Aval}, 16'h00FB);
    chk("add_X", {15'h0, X}, 16'h0001);
    cyc(8'hFB, 0, 0, 0, 0, 1);
    chk("shift_A", {8'h00, Aval}, 16'h00FD);
    chk("shift_X", {15'h0, X}, 16'h0001);
    chk("shift_B", {8'h00, Bval}, 16'h0083);

    // Asynchronous reset between clock edges.
    #1;
    Reset = 1'b1;
    #1;
    chk("arst_AB", {Aval, Bval}, 16'h0000);
    chk("arst_XM", {14'h0, X, M}, 16'h0000);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Add and Sub together: Sub wins. Add with shift: no shift.
    cyc(8'h5A, 1, 1, 0, 0, 0);
    cyc(8'h05, 0, 0, 1, 0, 0);
    chk("a05", {8'h00, Aval}, 16'h0005);
    cyc(8'h03, 0, 0, 1, 1, 0);
    chk("addsub_A", {8'h00, Aval}, 16'h0002);
    chk("addsub_X", {15'h0, X}, 16'h0000);
    cyc(8'h03, 0, 0, 1, 0, 1);
    chk("addsh_A", {8'h00, Aval}, 16'h0005);
    chk("addsh_B", {8'h00, Bval}, 16'h005A);

    // Load with shift: B loads, A still shifts.
    cyc(8'h3C, 1, 0, 0, 0, 1);
    chk("ldsh_A", {8'h00, Aval}, 16'h0002);
    chk("ldsh_B", {8'h00, Bval}, 16'h003C);

    // Clear with shift: A clears, B shifts in the old A[0].
    cyc(8'h01, 0, 0, 1, 0, 0);
    chk("a03", {8'h00, Aval}, 16'h0003);
    cyc(8'h00, 0, 1, 0, 0, 1);
    chk("clrsh_A", {8'h00, Aval}, 16'h0000);
    chk("clrsh_B", {8'h00, Bval}, 16'h009E);

    // Full multiplications with hand-computed products.
    run_mult(8'hFB, 8'h07, prod);
    chk("mul_FBx07", prod, 16'hFFDD);
    run_mult(8'h80, 8'h80, prod);
    chk("mul_80x80", prod, 16'h4000);
    run_mult(8'h7F, 8'h81, prod);
    chk("mul_7Fx81", prod, 16'hC0FF);
    run_mult(8'h81, 8'h7F, prod);
    chk("mul_81x7F", prod, 16'hC0FF);
    run_mult(8'hFF, 8'hFF, prod);
    chk("mul_FFxFF", prod, 16'h0001);

    // Random signed pairs against integer multiplication.
    for (int i = 0; i < 1000; i++) begin
      rs = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp_p = 16'($signed(rs) * $signed(rb));
      run_mult(rs, rb, prod);
      chk("mul_rand", prod, exp_p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
